// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        StPllRst,
        StWaitLock,
        StRelease,
        StRun,
        StFault
    } state_e;

    // Width that holds every value from 0 up to and including max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val) + 1;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Synchronises raw PLL LOCK and qualifies it with high/low run-length filters.
module pll_lock_filter
    import pll_seq_pkg::*;
#(
    parameter int unsigned LOCK_FILT = 64,
    parameter int unsigned LOSS_FILT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic pll_lock,
    output logic lock_ok,
    output logic lock_lost
);

    localparam int unsigned HiW = cnt_width(LOCK_FILT);
    localparam int unsigned LoW = cnt_width(LOSS_FILT);

    logic [1:0]     sync_q;
    logic           lock_s;
    logic [HiW-1:0] hi_q, hi_d;
    logic [LoW-1:0] lo_q, lo_d;

    assign lock_s = sync_q[1];

    // Run-length counters include the current cycle and saturate at their threshold.
    always_comb begin
        hi_d = '0;
        lo_d = '0;
        if (!clr) begin
            if (lock_s) begin
                hi_d = (hi_q == HiW'(LOCK_FILT)) ? hi_q : hi_q + HiW'(1);
            end else begin
                lo_d = (lo_q == LoW'(LOSS_FILT)) ? lo_q : lo_q + LoW'(1);
            end
        end
    end

    assign lock_ok   = (hi_d == HiW'(LOCK_FILT));
    assign lock_lost = (lo_d == LoW'(LOSS_FILT));

    // Two-flop synchroniser and run-length counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], pll_lock};
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL supervisor: PLL reset/power-down control, lock qualification, retries and
// staggered release of per-channel resets.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned RST_PULSE    = 16,
    parameter int unsigned LOCK_FILT    = 64,
    parameter int unsigned LOSS_FILT    = 4,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned CH_DELAY     = 8,
    parameter int unsigned MAX_RETRY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_lock,
    input  logic              relock_req,
    input  logic [NUM_CH-1:0] ch_en,
    output logic              pll_reset,
    output logic              pll_pwd,
    output logic [NUM_CH-1:0] ch_rst_o,
    output logic              ready,
    output logic              fault,
    output logic [3:0]        retry_cnt
);

    localparam int unsigned RelLen = NUM_CH * CH_DELAY;
    localparam int unsigned CntMax = max3(RST_PULSE, LOCK_TIMEOUT, RelLen);
    localparam int unsigned CntW   = cnt_width(CntMax);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [3:0]        retry_q, retry_d, retry_inc;
    logic              pll_reset_d, pll_pwd_d, ready_d, fault_d;
    logic [NUM_CH-1:0] ch_rst_d;
    logic              lock_ok, lock_lost, filt_clr;

    // Lock seen while the PLL is held in reset carries no information.
    assign filt_clr = (state_q == StPllRst);

    pll_lock_filter #(
        .LOCK_FILT (LOCK_FILT),
        .LOSS_FILT (LOSS_FILT)
    ) u_lock_filter (
        .clk       (clk),
        .rst       (rst),
        .clr       (filt_clr),
        .pll_lock  (pll_lock),
        .lock_ok   (lock_ok),
        .lock_lost (lock_lost)
    );

    assign cnt_inc   = cnt_q + CntW'(1);
    assign retry_inc = (retry_q == 4'hf) ? retry_q : retry_q + 4'd1;

    // Next-state logic; relock_req takes priority over loss and timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        retry_d = retry_q;
        unique case (state_q)
            StPllRst: begin
                if (cnt_inc == CntW'(RST_PULSE)) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (relock_req) begin
                    state_d = StPllRst;
                    retry_d = '0;
                end else if (lock_ok) begin
                    state_d = StRelease;
                end else if (cnt_inc == CntW'(LOCK_TIMEOUT)) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc >= 4'(MAX_RETRY)) ? StFault : StPllRst;
                end
            end
            StRelease, StRun: begin
                if (relock_req) begin
                    state_d = StPllRst;
                    retry_d = '0;
                end else if (lock_lost) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc >= 4'(MAX_RETRY)) ? StFault : StPllRst;
                end else if (state_q == StRelease && cnt_inc == CntW'(RelLen)) begin
                    state_d = StRun;
                    retry_d = '0;
                end
            end
            StFault: begin
                if (relock_req) begin
                    state_d = StPllRst;
                    retry_d = '0;
                end
            end
            default: state_d = StPllRst;
        endcase
        // Counter restarts on every state change and idles where nothing is timed.
        if (state_d != state_q || state_q == StRun || state_q == StFault) cnt_d = '0;
    end

    // Output decode from the next state so every output is a plain register.
    always_comb begin
        pll_reset_d = (state_d == StPllRst) || (state_d == StFault);
        pll_pwd_d   = (state_d == StFault);
        fault_d     = (state_d == StFault);
        ready_d     = (state_d == StRun);
        ch_rst_d    = '1;
        if (state_d == StRelease) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (ch_en[k] && cnt_d >= CntW'(k * CH_DELAY)) ch_rst_d[k] = 1'b0;
            end
        end else if (state_d == StRun) begin
            ch_rst_d = ~ch_en;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StPllRst;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pll_reset <= 1'b1;
            pll_pwd   <= 1'b0;
            ch_rst_o  <= '1;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            pll_reset <= pll_reset_d;
            pll_pwd   <= pll_pwd_d;
            ch_rst_o  <= ch_rst_d;
            ready     <= ready_d;
            fault     <= fault_d;
        end
    end

    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench: expected output vectors are queued per cycle and compared at negedge.
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       relock_req = 1'b0;
    logic [2:0] ch_en = 3'b111;
    logic       pll_reset, pll_pwd, ready, fault;
    logic [2:0] ch_rst_o;
    logic [3:0] retry_cnt;

    pll_lock_sequencer #(
        .NUM_CH       (3),
        .RST_PULSE    (4),
        .LOCK_FILT    (8),
        .LOSS_FILT    (2),
        .LOCK_TIMEOUT (100),
        .CH_DELAY     (3),
        .MAX_RETRY    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_lock   (pll_lock),
        .relock_req (relock_req),
        .ch_en      (ch_en),
        .pll_reset  (pll_reset),
        .pll_pwd    (pll_pwd),
        .ch_rst_o   (ch_rst_o),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt)
    );

    always #5 clk = ~clk;

    // Cycle 0 is the period right after the last edge that sampled rst high.
    int cyc = 0;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    typedef struct {
        int          cyc;
        string       tag;
        logic [10:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %b, expected %b (pll_reset pwd ch[2:0] ready fault retry)",
                     tag, obs, exp);
        end
    endtask

    function automatic void expect_at(input int c, input string tag, input logic pr,
                                      input logic pwd, input logic [2:0] ch, input logic rdy,
                                      input logic flt, input logic [3:0] rc);
        exp_t e;
        e.cyc = c;
        e.tag = $sformatf("%s@%0d", tag, c);
        e.v   = {pr, pwd, ch, rdy, flt, rc};
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!rst && sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            check_eq(mon_e.tag, {pll_reset, pll_pwd, ch_rst_o, ready, fault, retry_cnt}, mon_e.v);
        end
    end

    task automatic at(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        pll_lock = 1'b0;
        relock_req = 1'b0;
        ch_en = 3'b111;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge clk);
        check_eq({tag, "_drained"}, 11'(sb.size()), 11'd0);
        sb.delete();
    endtask

    // Lock from cycle 10 on a clean sequence: slots at 20/23/26, ready at 29.
    function automatic void push_nominal(input string tag);
        expect_at(0,  tag, 1, 0, 3'b111, 0, 0, 0);
        expect_at(3,  tag, 1, 0, 3'b111, 0, 0, 0);
        expect_at(4,  tag, 0, 0, 3'b111, 0, 0, 0);
        expect_at(19, tag, 0, 0, 3'b111, 0, 0, 0);
        expect_at(20, tag, 0, 0, 3'b110, 0, 0, 0);
        expect_at(22, tag, 0, 0, 3'b110, 0, 0, 0);
        expect_at(23, tag, 0, 0, 3'b100, 0, 0, 0);
        expect_at(25, tag, 0, 0, 3'b100, 0, 0, 0);
        expect_at(26, tag, 0, 0, 3'b000, 0, 0, 0);
        expect_at(28, tag, 0, 0, 3'b000, 0, 0, 0);
        expect_at(29, tag, 0, 0, 3'b000, 1, 0, 0);
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Nominal bring-up.
        do_reset();
        push_nominal("nominal");
        at(10);
        pll_lock = 1'b1;
        drain("nominal");

        // Glitchy lock never qualifies; timeout retries once.
        do_reset();
        expect_at(0,   "glitch", 1, 0, 3'b111, 0, 0, 0);
        expect_at(50,  "glitch", 0, 0, 3'b111, 0, 0, 0);
        expect_at(103, "glitch", 0, 0, 3'b111, 0, 0, 0);
        expect_at(104, "glitch", 1, 0, 3'b111, 0, 0, 1);
        expect_at(107, "glitch", 1, 0, 3'b111, 0, 0, 1);
        expect_at(108, "glitch", 0, 0, 3'b111, 0, 0, 1);
        for (int c = 0; c <= 110; c++) begin
            at(c);
            pll_lock = (c % 5 != 4);
        end
        drain("glitch");

        // Retry exhaustion, then software relock out of FAULT.
        do_reset();
        expect_at(0,   "exhaust", 1, 0, 3'b111, 0, 0, 0);
        expect_at(104, "exhaust", 1, 0, 3'b111, 0, 0, 1);
        expect_at(207, "exhaust", 0, 0, 3'b111, 0, 0, 1);
        expect_at(208, "exhaust", 1, 1, 3'b111, 0, 1, 2);
        expect_at(215, "exhaust", 1, 1, 3'b111, 0, 1, 2);
        expect_at(216, "exhaust", 1, 0, 3'b111, 0, 0, 0);
        expect_at(219, "exhaust", 1, 0, 3'b111, 0, 0, 0);
        expect_at(220, "exhaust", 0, 0, 3'b111, 0, 0, 0);
        at(215);
        relock_req = 1'b1;
        at(216);
        relock_req = 1'b0;
        drain("exhaust");

        // Lock loss in RUN: 1-cycle dip ignored, 2-cycle dip restarts, clean relock.
        do_reset();
        push_nominal("loss");
        expect_at(45, "loss", 0, 0, 3'b000, 1, 0, 0);
        expect_at(54, "loss", 1, 0, 3'b111, 0, 0, 1);
        expect_at(57, "loss", 1, 0, 3'b111, 0, 0, 1);
        expect_at(58, "loss", 0, 0, 3'b111, 0, 0, 1);
        expect_at(65, "loss", 0, 0, 3'b111, 0, 0, 1);
        expect_at(66, "loss", 0, 0, 3'b110, 0, 0, 1);
        expect_at(72, "loss", 0, 0, 3'b000, 0, 0, 1);
        expect_at(74, "loss", 0, 0, 3'b000, 0, 0, 1);
        expect_at(75, "loss", 0, 0, 3'b000, 1, 0, 0);
        at(10);
        pll_lock = 1'b1;
        at(40);
        pll_lock = 1'b0;
        at(41);
        pll_lock = 1'b1;
        at(50);
        pll_lock = 1'b0;
        at(52);
        pll_lock = 1'b1;
        drain("loss");

        // Channel disable during RELEASE, then enable changes in RUN.
        do_reset();
        expect_at(0,  "chen", 1, 0, 3'b111, 0, 0, 0);
        expect_at(20, "chen", 0, 0, 3'b110, 0, 0, 0);
        expect_at(23, "chen", 0, 0, 3'b110, 0, 0, 0);
        expect_at(26, "chen", 0, 0, 3'b010, 0, 0, 0);
        expect_at(29, "chen", 0, 0, 3'b010, 1, 0, 0);
        expect_at(32, "chen", 0, 0, 3'b010, 1, 0, 0);
        expect_at(33, "chen", 0, 0, 3'b000, 1, 0, 0);
        expect_at(36, "chen", 0, 0, 3'b001, 1, 0, 0);
        at(10);
        pll_lock = 1'b1;
        at(21);
        ch_en = 3'b101;
        at(32);
        ch_en = 3'b111;
        at(35);
        ch_en = 3'b110;
        drain("chen");

        // relock_req coincident with lock-loss qualification: no retry increment.
        do_reset();
        push_nominal("relock");
        expect_at(43, "relock", 0, 0, 3'b000, 1, 0, 0);
        expect_at(44, "relock", 1, 0, 3'b111, 0, 0, 0);
        expect_at(47, "relock", 1, 0, 3'b111, 0, 0, 0);
        expect_at(48, "relock", 0, 0, 3'b111, 0, 0, 0);
        at(10);
        pll_lock = 1'b1;
        at(40);
        pll_lock = 1'b0;
        at(42);
        pll_lock = 1'b1;
        at(43);
        relock_req = 1'b1;
        at(44);
        relock_req = 1'b0;
        drain("relock");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
